// File: rtl/orb_rx_pkg.sv
// orb_rx_pkg: shared types and constants for the orbital-data UART receiver.
//   rxState_e      receiver FSM state encoding
//   CLK_DIV_DEF    default clk cycles per serial bit
//   STROBE_LEN_DEF default strobe stretch length
//   STROBE_MIN     shortest strobe the word packer can catch (2-FF sync + 32-cycle window)
//   maj3()         3-input majority vote
package orb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAITIDLE
  } rxState_e;

  localparam int CLK_DIV_DEF    = 16;
  localparam int STROBE_LEN_DEF = 48;
  localparam int STROBE_MIN     = 34;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/orb_uart_rx_if.sv
// orb_uart_rx_if: serial input plus byte/strobe/error outputs of one receiver channel.
//   rx         serial line, idle high
//   oData      last accepted byte
//   oStrob     stretched strobe, high STROBE_LEN cycles per accepted byte
//   oFrameErr  1-cycle pulse, stop bit sampled low
//   oOverrun   1-cycle pulse, byte completed while oStrob still high
//   oParErr    1-cycle pulse, parity mismatch
// master: the receiver; slave: line driver / packer side.
interface orb_uart_rx_if;

  logic       rx;
  logic [7:0] oData;
  logic       oStrob;
  logic       oFrameErr;
  logic       oOverrun;
  logic       oParErr;

  modport master (
    input  rx,
    output oData, oStrob, oFrameErr, oOverrun, oParErr
  );

  modport slave (
    output rx,
    input  oData, oStrob, oFrameErr, oOverrun, oParErr
  );

endinterface

// File: rtl/orb_rx_sampler.sv
// orb_rx_sampler: 2-FF synchroniser, bit-period counter and 3-sample majority.
//   clk, rst   clock / async active-low reset
//   rxAsync    raw serial line
//   restart    realign the bit counter: the current cycle becomes cycle 0 of a bit
//   rxSync     synchronised line
//   fallEdge   synchronised line went 1 -> 0 this cycle
//   bitValid   1-cycle pulse at sample CLK_DIV/2+1 of every bit period
//   bitVal     majority of the samples at CLK_DIV/2-1, /2, /2+1 (valid with bitValid)
module orb_rx_sampler
  import orb_rx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rxAsync,
  input  logic restart,
  output logic rxSync,
  output logic fallEdge,
  output logic bitValid,
  output logic bitVal
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] SMP0 = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] SMP1 = CW'(CLK_DIV/2);
  localparam logic [CW-1:0] SMP2 = CW'(CLK_DIV/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic          sync1, sync2, rxPrev;
  logic [CW-1:0] cnt;
  logic          smpA, smpB;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      rxPrev <= 1'b1;
      cnt    <= '0;
      smpA   <= 1'b1;
      smpB   <= 1'b1;
    end else begin
      sync1  <= rxAsync;
      sync2  <= sync1;
      rxPrev <= sync2;
      // restart fires in the edge-detect cycle (bit cycle 0), so load 1 here
      if (restart)          cnt <= CW'(1);
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
      if (cnt == SMP0) smpA <= sync2;
      if (cnt == SMP1) smpB <= sync2;
    end
  end

  assign rxSync   = sync2;
  assign fallEdge = rxPrev & ~sync2;
  assign bitValid = (cnt == SMP2);
  // third sample is the live synced value in the bitValid cycle
  assign bitVal   = maj3(smpA, smpB, sync2);

endmodule

// File: rtl/orb_uart_rx.sv
// orb_uart_rx: serial byte receiver for one orbital-data channel, feeding the word packer.
//   clk   system clock
//   rst   async active-low reset
//   bus   orb_uart_rx_if.master (rx in; oData, oStrob, oFrameErr, oOverrun, oParErr out)
// Format 8N1 LSB first; with macro ORB_RX_PARITY_EN defined the format is 8E1 and
// bad parity drops the byte with an oParErr pulse. Without it oParErr is tied 0.
// oStrob is stretched STROBE_LEN cycles so the packer's synchroniser and write window
// see it; a byte finishing while oStrob is still high is dropped with oOverrun.
module orb_uart_rx
  import orb_rx_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int STROBE_LEN = STROBE_LEN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  orb_uart_rx_if.master  bus
);

  localparam int SW = $clog2(STROBE_LEN);
  localparam logic [SW-1:0] STB_LOAD = SW'(STROBE_LEN - 1);

  logic rxSync, fallEdge, bitValid, bitVal, restart;

  rxState_e    state;
  logic [2:0]  bitCnt;
  logic [7:0]  shReg;
  logic [7:0]  dataQ;
  logic        strobQ;
  logic [SW-1:0] strobeCnt;
  logic        frameErrQ, overrunQ;
  logic        parOk;

  assign restart = (state == IDLE) && fallEdge;

  orb_rx_sampler #(.CLK_DIV(CLK_DIV)) uSampler (
    .clk      (clk),
    .rst      (rst),
    .rxAsync  (bus.rx),
    .restart  (restart),
    .rxSync   (rxSync),
    .fallEdge (fallEdge),
    .bitValid (bitValid),
    .bitVal   (bitVal)
  );

`ifdef ORB_RX_PARITY_EN
  logic parBit, parErrQ;
  // even parity: the parity bit equals the XOR of the data bits
  assign parOk = (parBit == ^shReg);
`else
  assign parOk = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shReg     <= '0;
      dataQ     <= '0;
      strobQ    <= 1'b0;
      strobeCnt <= '0;
      frameErrQ <= 1'b0;
      overrunQ  <= 1'b0;
`ifdef ORB_RX_PARITY_EN
      parBit    <= 1'b0;
      parErrQ   <= 1'b0;
`endif
    end else begin
      frameErrQ <= 1'b0;
      overrunQ  <= 1'b0;
`ifdef ORB_RX_PARITY_EN
      parErrQ   <= 1'b0;
`endif
      // stretcher countdown; an accept only loads it while oStrob is low
      if (strobQ) begin
        if (strobeCnt == '0) strobQ    <= 1'b0;
        else                 strobeCnt <= strobeCnt - 1'b1;
      end

      case (state)
        IDLE: if (fallEdge) begin
          state  <= START;
          bitCnt <= '0;
        end
        START: if (bitValid) state <= bitVal ? IDLE : DATA;
        DATA: if (bitValid) begin
          shReg  <= {bitVal, shReg[7:1]};
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
`ifdef ORB_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef ORB_RX_PARITY_EN
        PARITY: if (bitValid) begin
          parBit <= bitVal;
          state  <= STOP;
        end
`endif
        STOP: if (bitValid) begin
          state <= WAITIDLE;
          if (!bitVal) frameErrQ <= 1'b1;
`ifdef ORB_RX_PARITY_EN
          if (!parOk)  parErrQ   <= 1'b1;
`endif
          if (bitVal && parOk) begin
            if (strobQ) overrunQ <= 1'b1;
            else begin
              dataQ     <= shReg;
              strobQ    <= 1'b1;
              strobeCnt <= STB_LOAD;
            end
          end
        end
        // hold here through a break so a long low line cannot retrigger
        WAITIDLE: if (rxSync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oData     = dataQ;
  assign bus.oStrob    = strobQ;
  assign bus.oFrameErr = frameErrQ;
  assign bus.oOverrun  = overrunQ;
`ifdef ORB_RX_PARITY_EN
  assign bus.oParErr   = parErrQ;
`else
  assign bus.oParErr   = 1'b0;
`endif

endmodule

// File: tb/tb_orb_uart_rx.sv
// tb_orb_uart_rx: directed bench for orb_uart_rx. Two instances share one serial line:
// uA with default STROBE_LEN=48, uB with STROBE_LEN=200 for the overrun case.
module tb_orb_uart_rx;
  import orb_rx_pkg::*;

  localparam int CDIV = 16;

  logic clk = 1'b0;
  logic rst;
  logic rxLine;

  always #5 clk = ~clk;

  orb_uart_rx_if uIfA ();
  orb_uart_rx_if uIfB ();
  assign uIfA.rx = rxLine;
  assign uIfB.rx = rxLine;

  orb_uart_rx #(.CLK_DIV(CDIV), .STROBE_LEN(48))  uA (.clk(clk), .rst(rst), .bus(uIfA));
  orb_uart_rx #(.CLK_DIV(CDIV), .STROBE_LEN(200)) uB (.clk(clk), .rst(rst), .bus(uIfB));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // output monitor, sampled on the falling edge
  int riseA = 0, feA = 0, ovA = 0, peA = 0, lenA = 0, gapA = 0;
  int hiRunA = 0, loRunA = 1000;
  logic prevA = 1'b0;
  logic [7:0] dLastA = '0, dPrevA = '0;
  int riseB = 0, ovB = 0;
  logic prevB = 1'b0;

  always @(negedge clk) begin
    if (uIfA.oStrob) begin
      if (!prevA) begin
        riseA++;
        gapA   = loRunA;
        loRunA = 0;
        dPrevA = dLastA;
        dLastA = uIfA.oData;
        hiRunA = 0;
      end
      hiRunA++;
    end else begin
      if (prevA) lenA = hiRunA;
      loRunA++;
    end
    prevA = uIfA.oStrob;
    if (uIfA.oFrameErr) feA++;
    if (uIfA.oOverrun)  ovA++;
    if (uIfA.oParErr)   peA++;
    if (uIfB.oStrob && !prevB) riseB++;
    prevB = uIfB.oStrob;
    if (uIfB.oOverrun) ovB++;
  end

  int sRise, sFe, sOv, sPe, sRiseB, sOvB;
  task automatic snap();
    sRise = riseA; sFe = feA; sOv = ovA; sPe = peA; sRiseB = riseB; sOvB = ovB;
  endtask

  task automatic sendBit(input logic b);
    rxLine = b;
    repeat (CDIV) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopB, input logic parB);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
`ifdef ORB_RX_PARITY_EN
    sendBit(parB);
`endif
    sendBit(stopB);
    rxLine = 1'b1;
  endtask

  initial begin
    logic [7:0] partial;
    rst = 1'b1;
    rxLine = 1'b1;
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstData",  32'(uIfA.oData), 32'h0);
    chk("rstStrob", 32'(uIfA.oStrob), 32'h0);
    chk("rstPulse", 32'({uIfA.oFrameErr, uIfA.oOverrun, uIfA.oParErr}), 32'h0);
    chk("rstState", 32'(uA.state), 32'(IDLE));
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // single clean byte
    snap();
    sendFrame(8'hA5, 1'b1, ^8'hA5);
    repeat (200) @(negedge clk);
    chk("a5Data", 32'(uIfA.oData), 32'hA5);
    chk("a5Rise", 32'(riseA - sRise), 32'd1);
    chk("a5Len",  32'(lenA), 32'd48);
    chk("a5Err",  32'((feA - sFe) + (ovA - sOv) + (peA - sPe)), 32'd0);

    // reset mid-byte, then a clean byte
    snap();
    partial = 8'h5A;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(partial[i]);
    rst = 1'b0;
    #1;
    chk("midRstData",  32'(uIfA.oData), 32'h0);
    chk("midRstStrob", 32'(uIfA.oStrob), 32'h0);
    chk("midRstState", 32'(uA.state), 32'(IDLE));
    rxLine = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    sendFrame(8'h3C, 1'b1, ^8'h3C);
    repeat (250) @(negedge clk);
    chk("3cData", 32'(uIfA.oData), 32'h3C);
    chk("3cRise", 32'(riseA - sRise), 32'd1);
    chk("3cErr",  32'((feA - sFe) + (ovA - sOv) + (peA - sPe)), 32'd0);

    // 4-cycle glitch on idle line
    snap();
    rxLine = 1'b0;
    repeat (4) @(negedge clk);
    rxLine = 1'b1;
    repeat (100) @(negedge clk);
    chk("glRise",  32'(riseA - sRise), 32'd0);
    chk("glErr",   32'((feA - sFe) + (ovA - sOv) + (peA - sPe)), 32'd0);
    chk("glState", 32'(uA.state), 32'(IDLE));

    // bad stop bit
    snap();
    sendFrame(8'h81, 1'b0, ^8'h81);
    repeat (200) @(negedge clk);
    chk("feCnt",  32'(feA - sFe), 32'd1);
    chk("feRise", 32'(riseA - sRise), 32'd0);
    chk("feData", 32'(uIfA.oData), 32'h3C);
    chk("feOv",   32'(ovA - sOv), 32'd0);

    // back-to-back frames
    snap();
    sendFrame(8'h11, 1'b1, ^8'h11);
    sendFrame(8'h22, 1'b1, ^8'h22);
    repeat (250) @(negedge clk);
    chk("b2bRise",  32'(riseA - sRise), 32'd2);
    chk("b2bFirst", 32'(dPrevA), 32'h11);
    chk("b2bLast",  32'(dLastA), 32'h22);
    chk("b2bGap",   32'(gapA >= 1), 32'd1);
    chk("b2bOvA",   32'(ovA - sOv), 32'd0);
    chk("ovRiseB",  32'(riseB - sRiseB), 32'd1);
    chk("ovCntB",   32'(ovB - sOvB), 32'd1);
    chk("ovDataB",  32'(uIfB.oData), 32'h11);

`ifdef ORB_RX_PARITY_EN
    // 0x07 has three ones: even parity bit should be 1, send 0
    snap();
    sendFrame(8'h07, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("peCnt",  32'(peA - sPe), 32'd1);
    chk("peRise", 32'(riseA - sRise), 32'd0);
    chk("peFe",   32'(feA - sFe), 32'd0);
    chk("peData", 32'(uIfA.oData), 32'h22);
`else
    chk("parTie", 32'(peA), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
